// File: rtl/digit_write_arbiter_pkg.sv
// Shared definitions for the digit write arbiter: FSM encoding,
// requester identifiers, the default digit limit and a one-hot helper.
package digit_write_arbiter_pkg;

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  typedef enum logic {REQ_A = 1'b0, REQ_B = 1'b1} req_id_t;

  localparam logic [3:0] DEFAULT_MAX_VAL = 4'd9;

  function automatic logic [3:0] digit_onehot(input logic [1:0] idx);
    logic [3:0] oh;
    oh = 4'b0000;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/digit_write_arbiter_rr_arb2.sv
// Two-way round-robin chooser: a lone eligible requester always wins,
// a contest goes to whichever side was not granted last.
module rr_arb2 (
  input  logic       elig_a,
  input  logic       elig_b,
  input  logic       last_b,
  output logic [1:0] win
);

  // winner select, bit0 = A, bit1 = B
  always_comb begin
    win = 2'b00;
    if (elig_a && elig_b) begin
      win = last_b ? 2'b01 : 2'b10;
    end else if (elig_a) begin
      win = 2'b01;
    end else if (elig_b) begin
      win = 2'b10;
    end else begin
      win = 2'b00;
    end
  end

endmodule

// File: rtl/digit_write_arbiter.sv
// Arbitrates digit-register writes between a counter source (A) and a
// user-edit source (B); each accepted write is followed by one HOLD cycle.
module digit_write_arbiter
  import digit_write_arbiter_pkg::*;
#(
  parameter logic [3:0] MAX_VAL = DEFAULT_MAX_VAL
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic [1:0] a_digit,
  input  logic [3:0] a_data,
  output logic       a_gnt,
  input  logic       b_req,
  input  logic [1:0] b_digit,
  input  logic [3:0] b_data,
  output logic       b_gnt,
  input  logic       b_lock,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] dig4,
  output logic [3:0] digit_to_update,
  output logic       wr_err
);

  state_t      state_r, next_state_s;
  req_id_t     last_r;
  logic [3:0]  digs_r [4];
  logic [3:0]  dtu_r;
  logic        a_gnt_r, b_gnt_r, wr_err_r;
  logic [1:0]  win_s;
  logic        grant_s;
  logic [1:0]  sel_digit_s;
  logic [3:0]  sel_data_s;
  logic        data_ok_s;

  rr_arb2 u_rr_arb2 (
    .elig_a (a_req && !b_lock),
    .elig_b (b_req),
    .last_b (last_r == REQ_B),
    .win    (win_s)
  );

  // grant qualification, write source mux and next state
  always_comb begin
    grant_s      = 1'b0;
    sel_digit_s  = a_digit;
    sel_data_s   = a_data;
    next_state_s = state_r;
    if (win_s[1]) begin
      sel_digit_s = b_digit;
      sel_data_s  = b_data;
    end else begin
      sel_digit_s = a_digit;
      sel_data_s  = a_data;
    end
    data_ok_s = (sel_data_s <= MAX_VAL);
    case (state_r)
      IDLE: begin
        grant_s      = (win_s != 2'b00);
        next_state_s = grant_s ? HOLD : IDLE;
      end
      HOLD: begin
        grant_s      = 1'b0;
        next_state_s = IDLE;
      end
      default: begin
        grant_s      = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  // state, last-grant, digit registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      last_r   <= REQ_B;
      dtu_r    <= 4'b0000;
      a_gnt_r  <= 1'b0;
      b_gnt_r  <= 1'b0;
      wr_err_r <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digs_r[i] <= 4'd0;
      end
    end else begin
      state_r  <= next_state_s;
      a_gnt_r  <= grant_s && win_s[0];
      b_gnt_r  <= grant_s && win_s[1];
      wr_err_r <= grant_s && !data_ok_s;
      if (grant_s) begin
        last_r <= win_s[1] ? REQ_B : REQ_A;
        // rejected data leaves both digits and marker untouched
        if (data_ok_s) begin
          digs_r[sel_digit_s] <= sel_data_s;
          dtu_r               <= digit_onehot(sel_digit_s);
        end
      end
    end
  end

  assign a_gnt           = a_gnt_r;
  assign b_gnt           = b_gnt_r;
  assign wr_err          = wr_err_r;
  assign digit_to_update = dtu_r;
  assign dig1            = digs_r[0];
  assign dig2            = digs_r[1];
  assign dig3            = digs_r[2];
  assign dig4            = digs_r[3];

endmodule

// File: tb/tb_digit_write_arbiter.sv
// Self-checking bench for digit_write_arbiter: directed vector table,
// corner-case sequences and random traffic against a behavioural model.
module tb_digit_write_arbiter;

  logic       clk = 1'b0;
  logic       rst, a_req, b_req, b_lock;
  logic [1:0] a_digit, b_digit;
  logic [3:0] a_data, b_data;
  logic       a_gnt, b_gnt, wr_err;
  logic [3:0] dig1, dig2, dig3, dig4, digit_to_update;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  int   m_dig [4];
  int   m_dtu;
  bit   m_busy;
  int   m_last;  // 0 = A, 1 = B
  bit   m_agnt, m_bgnt, m_err;

  typedef struct {
    bit       rst, areq; int adig, adat;
    bit       breq;      int bdig, bdat;
    bit       lock;
    bit       eag, ebg, eerr;
    int       edtu;
    int       edigs;  // {dig4,dig3,dig2,dig1} nibbles
  } vec_t;

  vec_t vecs [10];

  always #5 clk = ~clk;

  digit_write_arbiter dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_digit(a_digit), .a_data(a_data), .a_gnt(a_gnt),
    .b_req(b_req), .b_digit(b_digit), .b_data(b_data), .b_gnt(b_gnt),
    .b_lock(b_lock),
    .dig1(dig1), .dig2(dig2), .dig3(dig3), .dig4(dig4),
    .digit_to_update(digit_to_update), .wr_err(wr_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit ea, eb;
    int w, idx, dat;
    m_agnt = 0; m_bgnt = 0; m_err = 0;
    if (rst) begin
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
      m_dtu = 0; m_busy = 0; m_last = 1;
    end else if (m_busy) begin
      m_busy = 0;
    end else begin
      ea = a_req && !b_lock;
      eb = b_req;
      if (ea || eb) begin
        if (ea && eb) w = (m_last == 0) ? 1 : 0;
        else          w = ea ? 0 : 1;
        idx = (w == 0) ? int'(a_digit) : int'(b_digit);
        dat = (w == 0) ? int'(a_data)  : int'(b_data);
        if (w == 0) m_agnt = 1; else m_bgnt = 1;
        if (dat > 9) m_err = 1;
        else begin
          m_dig[idx] = dat;
          m_dtu = 1 << idx;
        end
        m_last = w;
        m_busy = 1;
      end
    end
  endtask

  task automatic compare_model();
    check("a_gnt", int'(a_gnt), int'(m_agnt));
    check("b_gnt", int'(b_gnt), int'(m_bgnt));
    check("wr_err", int'(wr_err), int'(m_err));
    check("digit_to_update", int'(digit_to_update), m_dtu);
    check("dig1", int'(dig1), m_dig[0]);
    check("dig2", int'(dig2), m_dig[1]);
    check("dig3", int'(dig3), m_dig[2]);
    check("dig4", int'(dig4), m_dig[3]);
    check("gnt_overlap", int'(a_gnt && b_gnt), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    rst = 0; a_req = 0; b_req = 0; b_lock = 0;
    a_digit = 2'd0; b_digit = 2'd0; a_data = 4'd0; b_data = 4'd0;
  endtask

  initial begin
    bit seen;
    idle_inputs();
    #2;

    // directed vector table, hand-derived expectations
    vecs[0] = '{1,1,2,7, 0,0,0, 0, 0,0,0, 4'b0000, 16'h0000};
    vecs[1] = '{0,1,2,7, 0,0,0, 0, 1,0,0, 4'b0100, 16'h0700};
    vecs[2] = '{0,1,2,7, 0,0,0, 0, 0,0,0, 4'b0100, 16'h0700};
    vecs[3] = '{0,0,0,0, 1,3,12,0, 0,1,1, 4'b0100, 16'h0700};
    vecs[4] = '{0,0,0,0, 0,3,12,0, 0,0,0, 4'b0100, 16'h0700};
    vecs[5] = '{0,1,0,1, 1,1,2, 0, 1,0,0, 4'b0001, 16'h0701};
    vecs[6] = '{0,1,0,1, 1,1,2, 0, 0,0,0, 4'b0001, 16'h0701};
    vecs[7] = '{0,1,0,1, 1,1,2, 0, 0,1,0, 4'b0010, 16'h0721};
    vecs[8] = '{0,1,0,1, 1,1,2, 0, 0,0,0, 4'b0010, 16'h0721};
    vecs[9] = '{0,1,0,5, 1,1,2, 0, 1,0,0, 4'b0001, 16'h0725};
    for (int i = 0; i < 10; i++) begin
      rst = vecs[i].rst; a_req = vecs[i].areq; b_req = vecs[i].breq;
      b_lock = vecs[i].lock;
      a_digit = 2'(vecs[i].adig); a_data = 4'(vecs[i].adat);
      b_digit = 2'(vecs[i].bdig); b_data = 4'(vecs[i].bdat);
      tick();
      check("vec_a_gnt", int'(a_gnt), int'(vecs[i].eag));
      check("vec_b_gnt", int'(b_gnt), int'(vecs[i].ebg));
      check("vec_wr_err", int'(wr_err), int'(vecs[i].eerr));
      check("vec_dtu", int'(digit_to_update), vecs[i].edtu);
      check("vec_digs", int'({dig4, dig3, dig2, dig1}), vecs[i].edigs);
    end
    idle_inputs();
    tick();

    // b_lock defers A for ten cycles, then A wins within two cycles
    a_req = 1; a_digit = 2'd3; a_data = 4'd3; b_lock = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("lock_no_a_gnt", int'(a_gnt), 0);
    end
    a_data = 4'd6;  // changed before the grant edge; this value must land
    b_lock = 0;
    seen = 0;
    for (int i = 0; i < 2 && !seen; i++) begin
      tick();
      if (a_gnt) seen = 1;
    end
    check("lock_release_a_gnt", int'(seen), 1);
    check("grant_edge_data", int'(dig4), 6);
    a_req = 0;
    tick();

    // reset during HOLD aborts, next contest goes to A
    a_req = 1; a_digit = 2'd1; a_data = 4'd4;
    tick();
    check("pre_rst_a_gnt", int'(a_gnt), 1);
    rst = 1; a_req = 0;
    tick();
    check("rst_hold_outputs",
          int'({a_gnt, b_gnt, wr_err, digit_to_update, dig1, dig2, dig3, dig4}), 0);
    rst = 0; a_req = 1; b_req = 1; a_digit = 2'd0; b_digit = 2'd1;
    a_data = 4'd2; b_data = 4'd3;
    tick();
    check("post_rst_contest_a", int'(a_gnt), 1);
    idle_inputs();
    tick();
    tick();

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(49, 0) == 0);
      a_req   = $urandom_range(1, 0) != 0;
      b_req   = $urandom_range(1, 0) != 0;
      b_lock  = ($urandom_range(3, 0) == 0);
      a_digit = 2'($urandom_range(3, 0));
      b_digit = 2'($urandom_range(3, 0));
      a_data  = 4'($urandom_range(15, 0));
      b_data  = 4'($urandom_range(15, 0));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/digit_write_arbiter.md
DIGIT_WRITE_ARBITER -- requirements
Module: digit_write_arbiter

Interface
REQ-001 Parameter: MAX_VAL, 9, largest legal digit value (4-bit); writes above it are rejected.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 a_req  input  1  write request from counter source A; held high until granted.
REQ-005 a_digit  input  2  target digit index for A (0 = dig1 .. 3 = dig4).
REQ-006 a_data  input  4  value A writes.
REQ-007 a_gnt  output  1  one-cycle grant pulse to A.
REQ-008 b_req, b_digit, b_data, b_gnt  same widths and directions as the A ports; user-edit source B.
REQ-009 b_lock  input  1  while high, A requests are held pending and never granted.
REQ-010 dig1, dig2, dig3, dig4  output  4 each  digit register contents feeding the display multiplexer.
REQ-011 digit_to_update  output  4  one-hot marker of the most recently written digit (bit0 = dig1).
REQ-012 wr_err  output  1  one-cycle pulse when a granted write is rejected (data > MAX_VAL).

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and HOLD.
REQ-014 In IDLE with at least one eligible request at edge k, the FSM SHALL enter HOLD and assert the winner's gnt for cycle k+1 only.
REQ-015 A is eligible when a_req=1 and b_lock=0; B is eligible when b_req=1.
REQ-016 With both A and B eligible, the grant SHALL go to the requester not granted last (round robin); last-grant holder resets to B, so A wins the first contest.
REQ-017 With only one requester eligible, it SHALL be granted regardless of last-grant; last-grant then updates to it.
REQ-018 On the granting edge k, the winner's digit register SHALL load its data, visible on digN in cycle k+1.
REQ-019 On that same edge, digit_to_update SHALL become the one-hot of the winner's digit index.
REQ-020 If winner data > MAX_VAL, no digit register SHALL change and digit_to_update SHALL hold; wr_err SHALL pulse in cycle k+1 alongside gnt.
REQ-021 HOLD SHALL last exactly one cycle, ignore all requests, and return to IDLE; sustained throughput is one write per two cycles.
REQ-022 A requester still asserting req in IDLE after its grant SHALL be treated as a new request.
REQ-023 a_gnt and b_gnt SHALL never be high in the same cycle; at most one gnt pulse occurs per HOLD entry.
REQ-024 b_lock rising while A waits SHALL defer A indefinitely without an error; A is granted in the first IDLE cycle after b_lock falls, subject to REQ-016.
REQ-025 Writes to the same digit from consecutive grants SHALL each take effect in grant order (last writer wins).
REQ-026 digit/data inputs SHALL be sampled only on the granting edge; changes at other times have no effect.

Reset
REQ-027 While rst=1 at an edge: state IDLE, dig1..dig4=0, digit_to_update=4'b0000, a_gnt=b_gnt=wr_err=0, last-grant=B.
REQ-028 Reset asserted while in HOLD SHALL abort to IDLE; the grant pulse from the previous edge is not extended and no further write occurs.
REQ-029 Requests present during reset SHALL be ignored; they are first evaluated in the first cycle after rst falls.

Structure
REQ-030 A shared package SHALL hold the FSM state encoding (IDLE, HOLD), the requester identifiers (REQ_A, REQ_B), and the default MAX_VAL.
REQ-031 The round-robin choice SHALL live in a sub-module rr_arb2 (two eligibility inputs, last-grant input, one-hot winner output, purely combinational).
REQ-032 Digit registers, FSM, last-grant, and output registers SHALL reside in digit_write_arbiter; no clock division or enables are inside this block.

Verification
REQ-033 Reset then A only: a_req=1, a_digit=2, a_data=7 -> a_gnt pulses one cycle, dig3=7 next cycle, digit_to_update=4'b0100.
REQ-034 A and B both requesting continuously from reset, A digit0 data 1, B digit1 data 2 -> grants alternate A,B,A,... every two cycles, no overlap.
REQ-035 b_lock=1 with a_req=1 for 10 cycles -> no a_gnt; lock drops -> a_gnt within 2 cycles.
REQ-036 B writes data 12 to digit3 (MAX_VAL=9) -> b_gnt and wr_err pulse together, dig4 and digit_to_update unchanged.
REQ-037 rst asserted in the HOLD cycle after a grant -> all outputs zero next cycle, next contested grant goes to A.
REQ-038 a_data changes between request and grant edge -> the value present on the grant edge is written.
